fetch_unit: RTL and testbench

- Front end of the swt16 pipeline: generates program-memory addresses, receives 16-bit instruction words and hands them, with their PC, to the decoder.
- Redirects to a jump target when execute resolves a jump.
- Drives the decoder's flush input to kill wrong-path words.
- Holds its output stable under a pipeline stall, using a one-entry skid buffer to absorb the in-flight memory word.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_skid_buffer.sv | 56 +++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode constants: widths, reset PC, NOP encoding and the fetch action type.
package fetch_unit_pkg;

  localparam int PMEM_ADDR_W      = 12;
  localparam int PMEM_WORD_W      = 16;
  localparam int PC_W             = 12;
  localparam int RESET_PC_DEF     = 0;
  localparam int FLUSH_CYCLES_DEF = 1;
  localparam int FLUSH_CNT_W      = 2;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    FS_RUN      = 2'd0,
    FS_STALL    = 2'd1,
    FS_REDIRECT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry word+pc holding register; clear beats load, load beats drain.
// Latency: stored entry is visible the cycle after load; no backpressure of its own.
module fetch_skid_buffer
  import fetch_unit_pkg::*;
#(
  parameter int WORD_WIDTH = PMEM_WORD_W,
  parameter int PC_WIDTH   = PC_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  drain_i,
  input  logic                  clear_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  output logic                  vld_o,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic [PC_WIDTH-1:0]   pc_o
);

  logic                  vld_q, vld_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;

  always_comb begin
    vld_d  = vld_q;
    word_d = word_q;
    pc_d   = pc_q;
    if (clear_i) begin
      vld_d = 1'b0;
    end else if (load_i) begin
      vld_d  = 1'b1;
      word_d = word_i;
      pc_d   = pc_i;
    end else if (drain_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q  <= 1'b0;
      word_q <= '0;
      pc_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      word_q <= word_d;
      pc_q   <= pc_d;
    end
  end

  assign vld_o  = vld_q;
  assign word_o = word_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// swt16 fetch: issues pmem addresses, delivers word+pc one per cycle (2-cycle address-to-decoder latency).
// Stall holds outputs and freezes the address; the one in-flight word lands in the skid buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PMEM_ADDR_WIDTH = PMEM_ADDR_W,
  parameter int PMEM_WORD_WIDTH = PMEM_WORD_W,
  parameter int PC_WIDTH        = PC_W,
  parameter int RESET_PC        = RESET_PC_DEF,
  parameter int FLUSH_CYCLES    = FLUSH_CYCLES_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_stall,
  input  logic                       in_jump,
  input  logic [PC_WIDTH-1:0]        in_jump_target,
  input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_data,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_valid,
  output logic                       out_flush
);

  localparam logic [PMEM_WORD_WIDTH-1:0] NOP = PMEM_WORD_WIDTH'(NOP_WORD);

  fetch_state_e mode;

  logic [PC_WIDTH-1:0]        addr_q, addr_d;
  logic                       pend_vld_q, pend_vld_d;
  logic [PC_WIDTH-1:0]        pend_pc_q, pend_pc_d;
  logic [FLUSH_CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic                       hold_vld_q, hold_vld_d;
  logic [PC_WIDTH-1:0]        hold_pc_q, hold_pc_d;
  logic [PMEM_WORD_WIDTH-1:0] hold_instr_q, hold_instr_d;

  logic                       skid_vld, skid_load, skid_drain, skid_clear;
  logic [PMEM_WORD_WIDTH-1:0] skid_word;
  logic [PC_WIDTH-1:0]        skid_pc;

  logic                       cur_vld;
  logic [PC_WIDTH-1:0]        cur_pc;
  logic [PMEM_WORD_WIDTH-1:0] cur_instr;

  fetch_skid_buffer #(
    .WORD_WIDTH (PMEM_WORD_WIDTH),
    .PC_WIDTH   (PC_WIDTH)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (skid_clear),
    .word_i  (in_pmem_data),
    .pc_i    (pend_pc_q),
    .vld_o   (skid_vld),
    .word_o  (skid_word),
    .pc_o    (skid_pc)
  );

  always_comb begin
    mode = FS_RUN;
    if (in_jump) begin
      mode = FS_REDIRECT;
    end else if (in_stall) begin
      mode = FS_STALL;
    end
  end

  // What the decoder sees on an unstalled cycle: skid entry first, else the memory word.
  always_comb begin
    cur_vld   = pend_vld_q;
    cur_pc    = pend_pc_q;
    cur_instr = pend_vld_q ? in_pmem_data : NOP;
    if (skid_vld) begin
      cur_vld   = 1'b1;
      cur_pc    = skid_pc;
      cur_instr = skid_word;
    end
  end

  always_comb begin
    addr_d       = addr_q;
    pend_vld_d   = 1'b0;
    pend_pc_d    = pend_pc_q;
    flush_cnt_d  = flush_cnt_q;
    hold_vld_d   = hold_vld_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    skid_load    = 1'b0;
    skid_drain   = 1'b0;
    skid_clear   = 1'b0;
    if (!in_stall && flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
    end
    case (mode)
      FS_REDIRECT: begin
        addr_d       = in_jump_target;
        flush_cnt_d  = FLUSH_CNT_W'(FLUSH_CYCLES);
        hold_vld_d   = 1'b0;
        hold_instr_d = NOP;
        skid_clear   = 1'b1;
      end
      FS_STALL: begin
        skid_load = pend_vld_q && !skid_vld;
      end
      FS_RUN: begin
        addr_d       = addr_q + PC_WIDTH'(1);
        pend_vld_d   = 1'b1;
        pend_pc_d    = addr_q;
        hold_vld_d   = cur_vld;
        hold_pc_d    = cur_pc;
        hold_instr_d = cur_instr;
        skid_load    = skid_vld && pend_vld_q;
        skid_drain   = skid_vld && !pend_vld_q;
      end
      default: begin
        addr_d = addr_q;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q       <= PC_WIDTH'(RESET_PC);
      pend_vld_q   <= 1'b0;
      pend_pc_q    <= '0;
      flush_cnt_q  <= '0;
      hold_vld_q   <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= NOP;
    end else begin
      addr_q       <= addr_d;
      pend_vld_q   <= pend_vld_d;
      pend_pc_q    <= pend_pc_d;
      flush_cnt_q  <= flush_cnt_d;
      hold_vld_q   <= hold_vld_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign out_pmem_addr = addr_q;
  assign out_instr     = in_stall ? hold_instr_q : cur_instr;
  assign out_pc        = in_stall ? hold_pc_q    : cur_pc;
  assign out_valid     = in_stall ? hold_vld_q   : cur_vld;
  assign out_flush     = reset && (in_jump || flush_cnt_q != '0);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random stall/jump traffic against a stream-level model.
module tb_fetch_unit;

  localparam int FLUSH_CYCLES = 1;
  localparam int RESET_PC     = 0;

  logic        clock;
  logic        reset;
  logic        in_stall;
  logic        in_jump;
  logic [11:0] in_jump_target;
  logic [15:0] in_pmem_data;
  logic [11:0] out_pmem_addr;
  logic [15:0] out_instr;
  logic [11:0] out_pc;
  logic        out_valid;
  logic        out_flush;

  logic [15:0] mem [4096];

  int errors = 0;
  int checks = 0;

  // Stream-level model: next pc owed, unstalled bubble cycles owed, flush cycles owed, last shown output.
  int          exp_pc;
  int          bubble;
  int          fcnt;
  logic        pv;
  logic [15:0] pi;
  logic [11:0] pp;
  logic [11:0] addr_seen;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .in_stall       (in_stall),
    .in_jump        (in_jump),
    .in_jump_target (in_jump_target),
    .in_pmem_data   (in_pmem_data),
    .out_pmem_addr  (out_pmem_addr),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_valid      (out_valid),
    .out_flush      (out_flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) in_pmem_data <= mem[out_pmem_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc = RESET_PC;
    bubble = 1;
    fcnt   = 0;
    pv     = 1'b0;
    pi     = 16'h0000;
    pp     = 12'h000;
  endtask

  task automatic cyc(input bit s, input bit j, input logic [11:0] t);
    bit          ev;
    bit          ef;
    logic [15:0] ei;
    logic [11:0] ep;
    in_stall       = s;
    in_jump        = j;
    in_jump_target = t;
    @(negedge clock);
    ef = j || (fcnt > 0);
    chk("flush", 32'(out_flush), 32'(ef));
    ep = pp;
    if (s) begin
      ev = pv;
      ei = pi;
    end else if (bubble > 0) begin
      ev = 1'b0;
      ei = 16'h0000;
      bubble--;
    end else begin
      ev     = 1'b1;
      ep     = 12'(exp_pc);
      ei     = mem[ep];
      exp_pc = (exp_pc + 1) % 4096;
    end
    chk("valid", 32'(out_valid), 32'(ev));
    chk("instr", 32'(out_instr), 32'(ei));
    if (ev) chk("pc", 32'(out_pc), 32'(ep));
    pv = ev;
    pi = ei;
    pp = ep;
    if (j) begin
      exp_pc = int'(t);
      bubble = 1;
      fcnt   = FLUSH_CYCLES;
      pv     = 1'b0;
      pi     = 16'h0000;
    end else if (!s && fcnt > 0) begin
      fcnt--;
    end
    addr_seen = out_pmem_addr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    in_stall       = 1'b0;
    in_jump        = 1'b0;
    in_jump_target = 12'h000;
    for (int a = 0; a < 4096; a++) mem[a] = 16'h1000 + 16'(a);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_addr", 32'(out_pmem_addr), 32'(RESET_PC));
    chk("rst_pc", 32'(out_pc), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_flush", 32'(out_flush), 32'h0);
    chk("rst_instr", 32'(out_instr), 32'h0);

    // Release, then stream until pc 5 is on the output.
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    repeat (7) cyc(1'b0, 1'b0, 12'h000);

    // Stall three cycles: address stays at pc+2 of the held word.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 12'h000);
      chk("stall_addr", 32'(addr_seen), 32'h007);
    end
    repeat (3) cyc(1'b0, 1'b0, 12'h000);

    // Jump to 0x0A0 while 0x010 is on the output.
    for (int k = 0; k < 64 && exp_pc != 16; k++) cyc(1'b0, 1'b0, 12'h000);
    chk("reach_pc10", 32'(exp_pc), 32'd16);
    cyc(1'b0, 1'b1, 12'h0A0);
    cyc(1'b0, 1'b0, 12'h000);
    chk("jump_addr", 32'(addr_seen), 32'h0A0);
    repeat (3) cyc(1'b0, 1'b0, 12'h000);

    // Jump together with a two-cycle stall.
    cyc(1'b1, 1'b1, 12'h3C0);
    cyc(1'b1, 1'b0, 12'h000);
    repeat (3) cyc(1'b0, 1'b0, 12'h000);

    // Fetch across the top of the address space.
    cyc(1'b0, 1'b1, 12'hFFC);
    repeat (7) cyc(1'b0, 1'b0, 12'h000);

    // Reset asserted in the cycle after a jump.
    cyc(1'b0, 1'b1, 12'h123);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_addr", 32'(out_pmem_addr), 32'(RESET_PC));
    chk("arst_flush", 32'(out_flush), 32'h0);
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_instr", 32'(out_instr), 32'h0);
    in_jump = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    repeat (6) cyc(1'b0, 1'b0, 12'h000);

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), 12'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
